// File: rtl/sequential_lsu_if.sv
// sequential_lsu_if: core request/response port plus Wishbone master port.
// master is the LSU side; slave is the core/bus environment side.
interface sequential_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [1:0]        req_type_i;
    logic              req_sign_i;
    logic [ADDR_W-1:0] req_adr_i;
    logic [31:0]       req_dat_i;
    logic              rsp_valid_o;
    logic [31:0]       rsp_dat_o;
    logic              rsp_err_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [3:0]        wb_sel_o;
    logic [31:0]       wb_dat_o;
    logic [31:0]       wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;

    modport master (
        input  req_valid_i, req_we_i, req_type_i, req_sign_i,
        input  req_adr_i, req_dat_i,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_type_i, req_sign_i,
        output req_adr_i, req_dat_i,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
    );
endinterface

// File: rtl/sequential_lsu.sv
// sequential_lsu: one-at-a-time load/store unit with a Wishbone master port.
// Define MISALIGN_SPLIT_EN to split misaligned accesses into two bus beats.
module sequential_lsu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    sequential_lsu_if.master bus
);

`ifdef MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0, BUS1 = 2'd1, BUS2 = 2'd2, RESP = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0, BUS1 = 2'd1, RESP = 2'd3
    } state_t;
`endif

    state_t r_state, w_state_n;

    logic              r_we, r_sign, r_err;
    logic [1:0]        r_type, r_off;
    logic [ADDR_W-1:0] r_wadr;
    logic [3:0]        r_sel;
    logic [31:0]       r_wdo, r_rdat, r_cnt;
`ifdef MISALIGN_SPLIT_EN
    logic              r_mis;
    logic [3:0]        r_hsel;
    logic [31:0]       r_hdat, r_beat1;
    logic [63:0]       w_wd;
    logic              w_last, w_split;
`else
    logic [31:0]       w_wd;
`endif

    logic [3:0]  w_lm;
    logic [7:0]  w_mask;
    logic        w_bad, w_to, w_bus;
    logic        w_accept, w_ok, w_fail, w_tick;
    logic [31:0] w_lo, w_hi, w_sh, w_ld;

    always_comb begin
        w_lm = 4'h0;
        unique case (bus.req_type_i)
            2'b11:   w_lm = 4'hF;
            2'b10:   w_lm = 4'h3;
            2'b01:   w_lm = 4'h1;
            default: w_lm = 4'h0;
        endcase
    end

    assign w_mask = {4'h0, w_lm} << bus.req_adr_i[1:0];
    assign w_to   = (TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1));

`ifdef MISALIGN_SPLIT_EN
    assign w_bad  = (bus.req_type_i == 2'b00);
    assign w_wd   = {32'h0, bus.req_dat_i} << {bus.req_adr_i[1:0], 3'b000};
    assign w_bus  = (r_state == BUS1) || (r_state == BUS2);
    assign w_last = (r_state == BUS2) || !r_mis;
    assign w_lo   = (r_state == BUS2) ? r_beat1 : bus.wb_dat_i;
    assign w_hi   = (r_state == BUS2) ? bus.wb_dat_i : 32'h0;
`else
    // Without splitting, any access crossing the word boundary is refused
    assign w_bad  = (bus.req_type_i == 2'b00) || (w_mask[7:4] != 4'h0);
    assign w_wd   = bus.req_dat_i << {bus.req_adr_i[1:0], 3'b000};
    assign w_bus  = (r_state == BUS1);
    assign w_lo   = bus.wb_dat_i;
    assign w_hi   = 32'h0;
`endif

    assign w_sh = 32'({w_hi, w_lo} >> {r_off, 3'b000});

    always_comb begin
        w_ld = w_sh;
        unique case (r_type)
            2'b10:   w_ld = {{16{r_sign & w_sh[15]}}, w_sh[15:0]};
            2'b01:   w_ld = {{24{r_sign & w_sh[7]}}, w_sh[7:0]};
            default: w_ld = w_sh;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_accept  = 1'b0;
        w_ok      = 1'b0;
        w_fail    = 1'b0;
        w_tick    = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        w_split   = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid_i) begin
                    w_accept  = 1'b1;
                    w_fail    = w_bad;
                    w_state_n = w_bad ? RESP : BUS1;
                end
            end
`ifdef MISALIGN_SPLIT_EN
            BUS1, BUS2: begin
`else
            BUS1: begin
`endif
                // Error beats ack, and ack beats the timeout
                if (bus.wb_err_i) begin
                    w_fail    = 1'b1;
                    w_state_n = RESP;
                end else if (bus.wb_ack_i) begin
                    w_ok      = 1'b1;
                    w_state_n = RESP;
`ifdef MISALIGN_SPLIT_EN
                    if (!w_last) begin
                        w_ok      = 1'b0;
                        w_split   = 1'b1;
                        w_state_n = BUS2;
                    end
`endif
                end else if (w_to) begin
                    w_fail    = 1'b1;
                    w_state_n = RESP;
                end else begin
                    w_tick    = 1'b1;
                end
            end
            RESP:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_sign  <= 1'b0;
            r_err   <= 1'b0;
            r_type  <= 2'b00;
            r_off   <= 2'b00;
            r_wadr  <= '0;
            r_sel   <= 4'h0;
            r_wdo   <= 32'h0;
            r_rdat  <= 32'h0;
            r_cnt   <= 32'h0;
`ifdef MISALIGN_SPLIT_EN
            r_mis   <= 1'b0;
            r_hsel  <= 4'h0;
            r_hdat  <= 32'h0;
            r_beat1 <= 32'h0;
`endif
        end else begin
            r_cnt <= w_tick ? r_cnt + 32'd1 : 32'd0;
            if (w_accept) begin
                r_we   <= bus.req_we_i;
                r_sign <= bus.req_sign_i;
                r_type <= bus.req_type_i;
                r_off  <= bus.req_adr_i[1:0];
                r_wadr <= {bus.req_adr_i[ADDR_W-1:2], 2'b00};
                r_sel  <= w_mask[3:0];
                r_wdo  <= w_wd[31:0];
`ifdef MISALIGN_SPLIT_EN
                r_mis  <= (w_mask[7:4] != 4'h0);
                r_hsel <= w_mask[7:4];
                r_hdat <= w_wd[63:32];
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            if (w_split) begin
                r_beat1 <= bus.wb_dat_i;
                r_wadr  <= r_wadr + ADDR_W'(4);
                r_sel   <= r_hsel;
                r_wdo   <= r_hdat;
            end
`endif
            if (w_ok) begin
                r_err  <= 1'b0;
                r_rdat <= r_we ? 32'h0 : w_ld;
            end
            if (w_fail) begin
                r_err  <= 1'b1;
                r_rdat <= 32'h0;
            end
        end
    end

    assign bus.req_ready_o = (r_state == IDLE);
    assign bus.rsp_valid_o = (r_state == RESP);
    assign bus.rsp_err_o   = (r_state == RESP) && r_err;
    assign bus.rsp_dat_o   = r_rdat;
    assign bus.wb_cyc_o    = w_bus;
    assign bus.wb_stb_o    = w_bus;
    assign bus.wb_we_o     = r_we;
    assign bus.wb_adr_o    = r_wadr;
    assign bus.wb_sel_o    = r_sel;
    assign bus.wb_dat_o    = r_wdo;

endmodule

// File: tb/tb_sequential_lsu.sv
// tb_sequential_lsu: directed vectors with hand-computed results for sequential_lsu.
// Split-access cases follow whether MISALIGN_SPLIT_EN is defined for the build.
module tb_sequential_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    sequential_lsu_if #(.ADDR_W(32)) lif ();

    sequential_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (lif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    // Presents a request for one cycle; returns at the negedge after acceptance
    task automatic issue(input logic we, input logic [1:0] typ, input logic sgn,
                         input logic [31:0] adr, input logic [31:0] dat);
        @(negedge clk);
        lif.req_valid_i = 1'b1;
        lif.req_we_i    = we;
        lif.req_type_i  = typ;
        lif.req_sign_i  = sgn;
        lif.req_adr_i   = adr;
        lif.req_dat_i   = dat;
        @(negedge clk);
        lif.req_valid_i = 1'b0;
    endtask

    task automatic beat(input int wait_n, input logic [31:0] rd,
                        input logic ack, input logic err);
        repeat (wait_n) @(negedge clk);
        lif.wb_dat_i = rd;
        lif.wb_ack_i = ack;
        lif.wb_err_i = err;
        @(negedge clk);
        lif.wb_ack_i = 1'b0;
        lif.wb_err_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        lif.req_valid_i = 1'b1;
        lif.req_type_i  = 2'b11;
        lif.req_adr_i   = 32'h100;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (lif.req_ready_o !== 1'b1) begin n_err++; $display("FAIL rst ready: got %b want 1", lif.req_ready_o); end
        n_chk++; if ({lif.wb_cyc_o, lif.wb_stb_o} !== 2'b00) begin n_err++; $display("FAIL rst cyc/stb: got %b want 00", {lif.wb_cyc_o, lif.wb_stb_o}); end
        n_chk++; if ({lif.wb_we_o, lif.rsp_valid_o, lif.rsp_err_o} !== 3'b000) begin n_err++; $display("FAIL rst we/valid/err: got %b want 000", {lif.wb_we_o, lif.rsp_valid_o, lif.rsp_err_o}); end
        n_chk++; if (lif.wb_adr_o !== 32'h0) begin n_err++; $display("FAIL rst adr: got %h want 0", lif.wb_adr_o); end
        n_chk++; if (lif.wb_sel_o !== 4'h0) begin n_err++; $display("FAIL rst sel: got %b want 0000", lif.wb_sel_o); end
        n_chk++; if (lif.wb_dat_o !== 32'h0) begin n_err++; $display("FAIL rst wdat: got %h want 0", lif.wb_dat_o); end
        n_chk++; if (lif.rsp_dat_o !== 32'h0) begin n_err++; $display("FAIL rst rdat: got %h want 0", lif.rsp_dat_o); end
        lif.req_valid_i = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_word_load;
        issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
        n_chk++; if ({lif.wb_cyc_o, lif.wb_stb_o, lif.wb_we_o} !== 3'b110) begin n_err++; $display("FAIL ldw cyc/stb/we: got %b want 110", {lif.wb_cyc_o, lif.wb_stb_o, lif.wb_we_o}); end
        n_chk++; if (lif.wb_adr_o !== 32'h100) begin n_err++; $display("FAIL ldw adr: got %h want 100", lif.wb_adr_o); end
        n_chk++; if (lif.wb_sel_o !== 4'b1111) begin n_err++; $display("FAIL ldw sel: got %b want 1111", lif.wb_sel_o); end
        n_chk++; if (lif.req_ready_o !== 1'b0) begin n_err++; $display("FAIL ldw busy ready: got %b want 0", lif.req_ready_o); end
        beat(2, 32'hDEADBEEF, 1'b1, 1'b0);
        n_chk++; if ({lif.rsp_valid_o, lif.rsp_err_o, lif.wb_cyc_o} !== 3'b100) begin n_err++; $display("FAIL ldw valid/err/cyc: got %b want 100", {lif.rsp_valid_o, lif.rsp_err_o, lif.wb_cyc_o}); end
        n_chk++; if (lif.rsp_dat_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL ldw rdat: got %h want deadbeef", lif.rsp_dat_o); end
        @(negedge clk);
        n_chk++; if ({lif.rsp_valid_o, lif.req_ready_o} !== 2'b01) begin n_err++; $display("FAIL ldw after valid/ready: got %b want 01", {lif.rsp_valid_o, lif.req_ready_o}); end
        n_chk++; if (lif.rsp_dat_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL ldw rdat hold: got %h want deadbeef", lif.rsp_dat_o); end
    endtask

    task automatic test_byte_load;
        issue(1'b0, 2'b01, 1'b1, 32'h103, 32'h0);
        n_chk++; if (lif.wb_sel_o !== 4'b1000) begin n_err++; $display("FAIL ldb sel: got %b want 1000", lif.wb_sel_o); end
        n_chk++; if (lif.wb_adr_o !== 32'h100) begin n_err++; $display("FAIL ldb adr: got %h want 100", lif.wb_adr_o); end
        beat(0, 32'h80112233, 1'b1, 1'b0);
        n_chk++; if (lif.rsp_dat_o !== 32'hFFFFFF80) begin n_err++; $display("FAIL ldb signed: got %h want ffffff80", lif.rsp_dat_o); end
        issue(1'b0, 2'b01, 1'b0, 32'h103, 32'h0);
        beat(0, 32'h80112233, 1'b1, 1'b0);
        n_chk++; if (lif.rsp_dat_o !== 32'h00000080) begin n_err++; $display("FAIL ldb unsigned: got %h want 00000080", lif.rsp_dat_o); end
    endtask

    task automatic test_store;
        issue(1'b1, 2'b11, 1'b0, 32'h200, 32'hCAFEF00D);
        n_chk++; if ({lif.wb_cyc_o, lif.wb_we_o, lif.wb_sel_o} !== 6'b11_1111) begin n_err++; $display("FAIL stw cyc/we/sel: got %b want 111111", {lif.wb_cyc_o, lif.wb_we_o, lif.wb_sel_o}); end
        n_chk++; if (lif.wb_dat_o !== 32'hCAFEF00D) begin n_err++; $display("FAIL stw wdat: got %h want cafef00d", lif.wb_dat_o); end
        beat(1, 32'h55555555, 1'b1, 1'b0);
        n_chk++; if ({lif.rsp_valid_o, lif.rsp_err_o} !== 2'b10) begin n_err++; $display("FAIL stw valid/err: got %b want 10", {lif.rsp_valid_o, lif.rsp_err_o}); end
        n_chk++; if (lif.rsp_dat_o !== 32'h0) begin n_err++; $display("FAIL stw rdat: got %h want 0", lif.rsp_dat_o); end
        issue(1'b1, 2'b01, 1'b0, 32'h201, 32'h000000AB);
        n_chk++; if (lif.wb_sel_o !== 4'b0010) begin n_err++; $display("FAIL stb sel: got %b want 0010", lif.wb_sel_o); end
        n_chk++; if (lif.wb_dat_o !== 32'h0000AB00) begin n_err++; $display("FAIL stb wdat: got %h want 0000ab00", lif.wb_dat_o); end
        beat(0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_half_load;
        issue(1'b0, 2'b10, 1'b1, 32'h102, 32'h0);
        n_chk++; if (lif.wb_sel_o !== 4'b1100) begin n_err++; $display("FAIL ldh2 sel: got %b want 1100", lif.wb_sel_o); end
        beat(0, 32'h80112233, 1'b1, 1'b0);
        n_chk++; if (lif.rsp_dat_o !== 32'hFFFF8011) begin n_err++; $display("FAIL ldh2 signed: got %h want ffff8011", lif.rsp_dat_o); end
        issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        n_chk++; if ({lif.wb_cyc_o, lif.wb_sel_o} !== 5'b1_0110) begin n_err++; $display("FAIL ldh1 cyc/sel: got %b want 10110", {lif.wb_cyc_o, lif.wb_sel_o}); end
        beat(0, 32'h80112233, 1'b1, 1'b0);
        n_chk++; if ({lif.rsp_valid_o, lif.rsp_err_o} !== 2'b10) begin n_err++; $display("FAIL ldh1 valid/err: got %b want 10", {lif.rsp_valid_o, lif.rsp_err_o}); end
        n_chk++; if (lif.rsp_dat_o !== 32'h00001122) begin n_err++; $display("FAIL ldh1 rdat: got %h want 00001122", lif.rsp_dat_o); end
    endtask

    task automatic test_invalid;
        issue(1'b0, 2'b00, 1'b0, 32'h400, 32'h0);
        n_chk++; if ({lif.wb_cyc_o, lif.rsp_valid_o, lif.rsp_err_o} !== 3'b011) begin n_err++; $display("FAIL inv cyc/valid/err: got %b want 011", {lif.wb_cyc_o, lif.rsp_valid_o, lif.rsp_err_o}); end
        n_chk++; if (lif.rsp_dat_o !== 32'h0) begin n_err++; $display("FAIL inv rdat: got %h want 0", lif.rsp_dat_o); end
    endtask

    task automatic test_misaligned;
`ifdef MISALIGN_SPLIT_EN
        issue(1'b1, 2'b11, 1'b0, 32'h0FE, 32'h11223344);
        n_chk++; if ({lif.wb_cyc_o, lif.wb_we_o, lif.wb_sel_o} !== 6'b11_1100) begin n_err++; $display("FAIL split b1 cyc/we/sel: got %b want 111100", {lif.wb_cyc_o, lif.wb_we_o, lif.wb_sel_o}); end
        n_chk++; if (lif.wb_adr_o !== 32'h0FC) begin n_err++; $display("FAIL split b1 adr: got %h want 0fc", lif.wb_adr_o); end
        n_chk++; if (lif.wb_dat_o !== 32'h33440000) begin n_err++; $display("FAIL split b1 wdat: got %h want 33440000", lif.wb_dat_o); end
        beat(0, 32'h0, 1'b1, 1'b0);
        n_chk++; if ({lif.wb_cyc_o, lif.wb_stb_o, lif.wb_sel_o} !== 6'b11_0011) begin n_err++; $display("FAIL split b2 cyc/stb/sel: got %b want 110011", {lif.wb_cyc_o, lif.wb_stb_o, lif.wb_sel_o}); end
        n_chk++; if (lif.wb_adr_o !== 32'h100) begin n_err++; $display("FAIL split b2 adr: got %h want 100", lif.wb_adr_o); end
        n_chk++; if (lif.wb_dat_o !== 32'h00001122) begin n_err++; $display("FAIL split b2 wdat: got %h want 00001122", lif.wb_dat_o); end
        beat(0, 32'h0, 1'b1, 1'b0);
        n_chk++; if ({lif.rsp_valid_o, lif.rsp_err_o, lif.wb_cyc_o} !== 3'b100) begin n_err++; $display("FAIL split st resp: got %b want 100", {lif.rsp_valid_o, lif.rsp_err_o, lif.wb_cyc_o}); end
        issue(1'b0, 2'b11, 1'b0, 32'h0FE, 32'h0);
        beat(0, 32'h44332211, 1'b1, 1'b0);
        n_chk++; if ({lif.wb_cyc_o, lif.wb_sel_o} !== 5'b1_0011) begin n_err++; $display("FAIL split ld b2 cyc/sel: got %b want 10011", {lif.wb_cyc_o, lif.wb_sel_o}); end
        beat(0, 32'h88776655, 1'b1, 1'b0);
        n_chk++; if (lif.rsp_dat_o !== 32'h66554433) begin n_err++; $display("FAIL split ld rdat: got %h want 66554433", lif.rsp_dat_o); end
`else
        issue(1'b1, 2'b11, 1'b0, 32'h0FE, 32'h11223344);
        n_chk++; if ({lif.wb_cyc_o, lif.rsp_valid_o, lif.rsp_err_o} !== 3'b011) begin n_err++; $display("FAIL mis word cyc/valid/err: got %b want 011", {lif.wb_cyc_o, lif.rsp_valid_o, lif.rsp_err_o}); end
        issue(1'b0, 2'b10, 1'b0, 32'h103, 32'h0);
        n_chk++; if ({lif.wb_cyc_o, lif.rsp_valid_o, lif.rsp_err_o} !== 3'b011) begin n_err++; $display("FAIL mis half cyc/valid/err: got %b want 011", {lif.wb_cyc_o, lif.rsp_valid_o, lif.rsp_err_o}); end
`endif
    endtask

    task automatic test_timeout;
        int  stb_n;
        logic seen;
        stb_n = 0;
        seen  = 1'b0;
        issue(1'b0, 2'b11, 1'b0, 32'h300, 32'h0);
        for (int i = 0; i < 12 && !seen; i++) begin
            if (lif.rsp_valid_o) seen = 1'b1;
            else begin
                if (lif.wb_stb_o) stb_n++;
                @(negedge clk);
            end
        end
        n_chk++; if (seen !== 1'b1) begin n_err++; $display("FAIL tmo resp seen: got %b want 1", seen); end
        n_chk++; if (stb_n !== 4) begin n_err++; $display("FAIL tmo stb cycles: got %0d want 4", stb_n); end
        n_chk++; if (lif.rsp_err_o !== 1'b1) begin n_err++; $display("FAIL tmo err: got %b want 1", lif.rsp_err_o); end
        issue(1'b0, 2'b11, 1'b0, 32'h304, 32'h0);
        beat(3, 32'h12345678, 1'b1, 1'b0);
        n_chk++; if ({lif.rsp_valid_o, lif.rsp_err_o} !== 2'b10) begin n_err++; $display("FAIL tmo ack wins: got %b want 10", {lif.rsp_valid_o, lif.rsp_err_o}); end
        n_chk++; if (lif.rsp_dat_o !== 32'h12345678) begin n_err++; $display("FAIL tmo ack rdat: got %h want 12345678", lif.rsp_dat_o); end
    endtask

    task automatic test_bus_err;
        issue(1'b0, 2'b11, 1'b0, 32'h500, 32'h0);
        beat(1, 32'hFFFFFFFF, 1'b0, 1'b1);
        n_chk++; if ({lif.rsp_valid_o, lif.rsp_err_o} !== 2'b11) begin n_err++; $display("FAIL berr valid/err: got %b want 11", {lif.rsp_valid_o, lif.rsp_err_o}); end
        n_chk++; if (lif.rsp_dat_o !== 32'h0) begin n_err++; $display("FAIL berr rdat: got %h want 0", lif.rsp_dat_o); end
        issue(1'b0, 2'b11, 1'b0, 32'h504, 32'h0);
        beat(0, 32'hAAAA5555, 1'b1, 1'b1);
        n_chk++; if ({lif.rsp_valid_o, lif.rsp_err_o} !== 2'b11) begin n_err++; $display("FAIL berr over ack: got %b want 11", {lif.rsp_valid_o, lif.rsp_err_o}); end
        n_chk++; if (lif.rsp_dat_o !== 32'h0) begin n_err++; $display("FAIL berr over ack rdat: got %h want 0", lif.rsp_dat_o); end
`ifdef MISALIGN_SPLIT_EN
        issue(1'b1, 2'b11, 1'b0, 32'h0FE, 32'h11223344);
        beat(0, 32'h0, 1'b0, 1'b1);
        n_chk++; if ({lif.wb_cyc_o, lif.rsp_valid_o, lif.rsp_err_o} !== 3'b011) begin n_err++; $display("FAIL berr split resp: got %b want 011", {lif.wb_cyc_o, lif.rsp_valid_o, lif.rsp_err_o}); end
        @(negedge clk);
        n_chk++; if (lif.wb_cyc_o !== 1'b0) begin n_err++; $display("FAIL berr split no beat2: got %b want 0", lif.wb_cyc_o); end
`endif
    endtask

    task automatic test_midreset;
        int pulses;
        pulses = 0;
        issue(1'b0, 2'b11, 1'b0, 32'h600, 32'h0);
        n_chk++; if (lif.wb_cyc_o !== 1'b1) begin n_err++; $display("FAIL mrst pre cyc: got %b want 1", lif.wb_cyc_o); end
        rst = 1'b1;
        #1;
        n_chk++; if ({lif.wb_cyc_o, lif.wb_stb_o} !== 2'b00) begin n_err++; $display("FAIL mrst cyc/stb: got %b want 00", {lif.wb_cyc_o, lif.wb_stb_o}); end
        n_chk++; if ({lif.req_ready_o, lif.rsp_valid_o} !== 2'b10) begin n_err++; $display("FAIL mrst ready/valid: got %b want 10", {lif.req_ready_o, lif.rsp_valid_o}); end
        lif.wb_ack_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lif.wb_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (lif.rsp_valid_o) pulses++;
        end
        n_chk++; if (pulses !== 0) begin n_err++; $display("FAIL mrst rsp pulses: got %0d want 0", pulses); end
        n_chk++; if ({lif.req_ready_o, lif.wb_cyc_o} !== 2'b10) begin n_err++; $display("FAIL mrst after ready/cyc: got %b want 10", {lif.req_ready_o, lif.wb_cyc_o}); end
    endtask

    initial begin
        lif.req_valid_i = 1'b0;
        lif.req_we_i    = 1'b0;
        lif.req_type_i  = 2'b00;
        lif.req_sign_i  = 1'b0;
        lif.req_adr_i   = 32'h0;
        lif.req_dat_i   = 32'h0;
        lif.wb_dat_i    = 32'h0;
        lif.wb_ack_i    = 1'b0;
        lif.wb_err_i    = 1'b0;
        test_reset();
        test_word_load();
        test_byte_load();
        test_store();
        test_half_load();
        test_invalid();
        test_misaligned();
        test_timeout();
        test_bus_err();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sequential_lsu.md
SEQUENTIAL_LSU -- requirements
Module: sequential_lsu

Interface
REQ-001 Parameter: ADDR_W, default 32, address width in bits (minimum 3).
REQ-002 Parameter: TIMEOUT, default 255, bus-wait cycles before abort; 0 disables timeout.
REQ-003 Data width is fixed at 32 bits, with four byte lanes.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 req_valid_i  in  1  core request present; req_ready_o  out  1  block can accept a request.
REQ-007 req_we_i  in  1  store when 1, load when 0; req_type_i  in  2  11=word, 10=half, 01=byte, 00=invalid; req_sign_i  in  1  sign-extend loads.
REQ-008 req_adr_i  in  ADDR_W  byte address; req_dat_i  in  32  store data, right-aligned.
REQ-009 rsp_valid_o  out  1  one-cycle completion pulse; rsp_dat_o  out  32  load result; rsp_err_o  out  1  access failed.
REQ-010 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  bus cycle, strobe and write-enable; wb_adr_o  out  ADDR_W  word-aligned address; wb_sel_o  out  4  byte lanes; wb_dat_o  out  32  write data.
REQ-011 wb_dat_i  in  32  read data; wb_ack_i  in  1  transfer done; wb_err_i  in  1  bus error.

Function
REQ-012 The FSM shall have the states IDLE, BUS1, BUS2 and RESP; req_ready_o shall be 1 only in IDLE.
REQ-013 A request is accepted when req_valid_i and req_ready_o are both high (cycle T); all request fields shall be registered at T.
REQ-014 A valid type shall move the FSM to BUS1, and wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o and wb_dat_o shall be driven from registers starting at T+1.
REQ-015 Byte mask: m[7:0] = ((1<<size)-1) << adr[1:0], where size is 1, 2 or 4 bytes; the first beat shall use wb_sel_o=m[3:0] at {adr[ADDR_W-1:2],2'b00}.
REQ-016 Store data shall be the 64-bit value {32'b0,req_dat_i} shifted left by 8*adr[1:0]; the low 32 bits go to the first beat and the high 32 bits to the second.
REQ-017 A request is misaligned when m[7:4] != 0; a half at offset 1 and any byte access are aligned.
REQ-018 In BUS1, on wb_ack_i for an aligned request, or for the second beat, the FSM shall go to RESP; on wb_ack_i for the first beat of a split request, it shall go to BUS2.
REQ-019 BUS2 shall keep wb_cyc_o and wb_stb_o high and drive address+4 (wrapping modulo 2^ADDR_W), wb_sel_o=m[7:4], and the high store word.
REQ-020 Load result: the beats shall be combined as {beat2,beat1} >> 8*adr[1:0], the low size bytes taken, and the result sign-extended if req_sign_i is 1, else zero-extended.
REQ-021 RESP shall last exactly one cycle with rsp_valid_o=1, then return to IDLE; wb_cyc_o and wb_stb_o shall be 0 in RESP.
REQ-022 rsp_dat_o shall be 0 for stores and for errors, and shall hold its value until the next rsp_valid_o.
REQ-023 A wb_err_i in any beat shall end the transaction: go to RESP with rsp_err_o=1, and issue no further beat.
REQ-024 If wb_ack_i and wb_err_i are high in the same cycle, the error shall win.
REQ-025 A timeout counter shall count cycles with wb_stb_o high and no ack or error, and shall clear on each new beat.
REQ-026 When the counter reaches TIMEOUT (and TIMEOUT is not 0), the transaction shall abort with rsp_err_o=1; an ack arriving in that same cycle shall win over the timeout.
REQ-027 An invalid type (00) shall generate no bus cycle, and shall give RESP with rsp_err_o=1 at T+1.

Reset
REQ-028 While rst_i=1, the state shall be IDLE and every output shall be 0 except req_ready_o=1, regardless of the clock.
REQ-029 Reset in the middle of a transaction shall drop wb_cyc_o and wb_stb_o immediately and discard the transaction, with no response pulse.

Configuration
REQ-030 Macro MISALIGN_SPLIT_EN: when defined, misaligned requests shall be split into two beats as in REQ-015 to REQ-020.
REQ-031 When MISALIGN_SPLIT_EN is undefined, a misaligned request shall issue no bus cycle and shall give RESP with rsp_err_o=1 at T+1; the BUS2 state shall not be present.

Verification
REQ-032 Word load at 0x100, slave acks 2 cycles after strobe with wb_dat_i=0xDEADBEEF -> sel=1111, rsp_dat_o=0xDEADBEEF, rsp_err_o=0.
REQ-033 Signed byte load at 0x103 with wb_dat_i=0x80112233 -> sel=1000, rsp_dat_o=0xFFFFFF80; the same load unsigned -> 0x00000080.
REQ-034 With the macro defined, word store 0x11223344 at 0x0FE -> beat 1: adr 0x0FC, sel 1100, dat 0x33440000; beat 2: adr 0x100, sel 0011, dat 0x00001122; wb_cyc_o stays continuous across both beats.
REQ-035 The same access with the macro undefined -> no wb_cyc_o, and rsp_err_o=1 one cycle after acceptance.
REQ-036 TIMEOUT=4 with a slave that never acks -> wb_stb_o high for 4 cycles, then rsp_err_o=1; a second run with wb_err_i on beat 1 of a split access -> no beat 2 is issued.
REQ-037 rst_i pulsed high while in BUS1 -> wb_cyc_o=0 immediately, no rsp_valid_o, and req_ready_o=1.
